baud_rate_gen_frac: RTL and testbench

- Programmable successor to the fixed 50 MHz / 9600 baud UART clock-enable generator.
- Uses a fractional phase accumulator (N/2^ACC_WIDTH), so any baud rate is reachable without integer-division error.
- The divisor can be changed at runtime without glitches.
- The RX oversample phase can be re-centred on a start-bit edge.
- Sits between the system clock and the UART rx/tx FSMs, which consume single-cycle enables.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/phase_acc.sv | 40 ++++
 rtl/baud_rate_gen_frac.sv | 97 +++++++++
 tb/tb_baud_rate_gen_frac.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: phase-increment calculation for the fractional
// baud generator and the increments for the common baud rates.
package uart_pkg;

    // Rounded baud*os*2^width/clk_hz in 64-bit arithmetic.
    function automatic longint unsigned calc_inc(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input longint unsigned os,
        input longint unsigned width
    );
        longint unsigned num;
        num = baud * os * (64'd1 << width);
        return (num + clk_hz / 64'd2) / clk_hz;
    endfunction

    localparam longint unsigned BAUD_9600_INC   = calc_inc(64'd50000000, 64'd9600, 64'd16, 64'd24);
    localparam longint unsigned BAUD_115200_INC = calc_inc(64'd50000000, 64'd115200, 64'd16, 64'd24);

endpackage

// File: rtl/phase_acc.sv
// Wrapping phase accumulator: overflow of acc + inc is the tick, the
// remainder is kept so the long-run tick rate is exact.
module phase_acc #(
    parameter int unsigned ACC_WIDTH = 24
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [ACC_WIDTH-1:0] inc,
    input  logic                 preset,
    input  logic [ACC_WIDTH-1:0] preset_val,
    input  logic                 tick_gate,
    output logic                 carry,
    output logic                 tick
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc};

    // Preset overrides the add, so a coincident overflow never counts.
    assign carry = en && !preset && sum[ACC_WIDTH];

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (preset) begin
            acc  <= preset_val;
            tick <= 1'b0;
        end else if (en) begin
            acc  <= sum[ACC_WIDTH-1:0];
            tick <= carry && tick_gate;
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_rate_gen_frac.sv
// Programmable fractional baud-rate enable generator: independent rx and tx
// phase accumulators sharing one runtime-loadable increment.
module baud_rate_gen_frac
    import uart_pkg::*;
#(
    parameter int unsigned     CLK_HZ       = 50000000,
    parameter int unsigned     DEFAULT_BAUD = 9600,
    parameter int unsigned     OVERSAMPLE   = 16,
    parameter int unsigned     ACC_WIDTH    = 24,
    parameter longint unsigned DEFAULT_INC  = calc_inc(64'(CLK_HZ), 64'(DEFAULT_BAUD),
                                                       64'(OVERSAMPLE), 64'(ACC_WIDTH))
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [ACC_WIDTH-1:0] inc_in,
    input  logic                 inc_load,
    output logic                 inc_busy,
    input  logic                 rx_resync,
    output logic                 rxclk_en,
    output logic                 txclk_en
);

    localparam int unsigned          DIV_W    = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(OVERSAMPLE - 1);
    localparam logic [ACC_WIDTH-1:0] INC_RST  = DEFAULT_INC[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] RX_MID   = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    if (OVERSAMPLE < 2 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
        $error("OVERSAMPLE must be a power of two, at least 2");
    end
    if (ACC_WIDTH < 8) begin : g_bad_w
        $error("ACC_WIDTH must be at least 8");
    end

    logic [ACC_WIDTH-1:0] inc_q;
    logic [ACC_WIDTH-1:0] inc_pend;
    logic [DIV_W-1:0]     tx_div;
    logic                 c_rx;
    logic                 c_tx;
    logic                 inc_apply;

    // A new increment only lands at an rx wrap (or while stopped), so the
    // period in flight is never cut short.
    assign inc_apply = inc_busy && (c_rx || !en);

    phase_acc #(.ACC_WIDTH(ACC_WIDTH)) u_rx_acc (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .en         (en),
        .inc        (inc_q),
        .preset     (rx_resync),
        .preset_val (RX_MID),
        .tick_gate  (1'b1),
        .carry      (c_rx),
        .tick       (rxclk_en)
    );

    phase_acc #(.ACC_WIDTH(ACC_WIDTH)) u_tx_acc (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .en         (en),
        .inc        (inc_q),
        .preset     (1'b0),
        .preset_val ('0),
        .tick_gate  (tx_div == DIV_LAST),
        .carry      (c_tx),
        .tick       (txclk_en)
    );

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_div <= '0;
        end else if (c_tx) begin
            tx_div <= (tx_div == DIV_LAST) ? '0 : tx_div + 1'b1;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            inc_q    <= INC_RST;
            inc_pend <= '0;
            inc_busy <= 1'b0;
        end else begin
            if (inc_apply) begin
                inc_q <= inc_pend;
            end
            if (inc_load) begin
                inc_pend <= inc_in;
                inc_busy <= 1'b1;
            end else if (inc_apply) begin
                inc_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_baud_rate_gen_frac.sv
// Bench for baud_rate_gen_frac: an 8-bit instance against a total-phase
// reference model, plus a default 24-bit instance for the reset rate.
module tb_baud_rate_gen_frac;

    localparam longint DEF8  = (64'd9600 * 64'd16 * 64'd256 + 64'd25000000) / 64'd50000000;
    localparam longint INC24 = 51540;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b1;

    logic       en = 1'b0, inc_load = 1'b0, rx_resync = 1'b0;
    logic [7:0] inc_in = '0;
    logic       rx8, tx8, busy8;

    logic        en24 = 1'b1, inc_load24 = 1'b0, rx_resync24 = 1'b0;
    logic [23:0] inc_in24 = '0;
    logic        rx24, tx24, busy24;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    longint rx_ph, tx_ph, tx_carries, n24, r24, t24;
    logic [7:0] m_inc, m_pend;
    bit m_busy, e_rx, e_tx;

    always #5 clk_50m = ~clk_50m;

    baud_rate_gen_frac #(.ACC_WIDTH(8)) dut8 (
        .clk_50m (clk_50m), .rst_n (rst_n), .en (en), .inc_in (inc_in),
        .inc_load (inc_load), .inc_busy (busy8), .rx_resync (rx_resync),
        .rxclk_en (rx8), .txclk_en (tx8)
    );

    baud_rate_gen_frac dut24 (
        .clk_50m (clk_50m), .rst_n (rst_n), .en (en24), .inc_in (inc_in24),
        .inc_load (inc_load24), .inc_busy (busy24), .rx_resync (rx_resync24),
        .rxclk_en (rx24), .txclk_en (tx24)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: predict from the current inputs, clock, then compare.
    task automatic step();
        bit c_rx, c_tx, apply;
        c_rx = 1'b0;
        c_tx = 1'b0;
        if (!rst_n) begin
            rx_ph = 0; tx_ph = 0; tx_carries = 0;
            m_inc = 8'(DEF8); m_pend = '0; m_busy = 1'b0;
            e_rx = 1'b0; e_tx = 1'b0;
            n24 = 0; r24 = 0; t24 = 0;
        end else begin
            e_tx = 1'b0;
            if (rx_resync) begin
                rx_ph = ((rx_ph >> 8) << 8) + 128;
            end else if (en) begin
                c_rx  = ((rx_ph + longint'(m_inc)) >> 8) != (rx_ph >> 8);
                rx_ph = rx_ph + longint'(m_inc);
            end
            e_rx = c_rx;
            if (en) begin
                c_tx  = ((tx_ph + longint'(m_inc)) >> 8) != (tx_ph >> 8);
                tx_ph = tx_ph + longint'(m_inc);
                if (c_tx) begin
                    tx_carries = tx_carries + 1;
                    e_tx = (tx_carries % 16) == 0;
                end
            end
            apply = m_busy && (c_rx || !en);
            if (apply) m_inc = m_pend;
            if (inc_load) begin
                m_pend = inc_in;
                m_busy = 1'b1;
            end else if (apply) begin
                m_busy = 1'b0;
            end
            n24 = n24 + 1;
        end
        @(posedge clk_50m);
        #1;
        chk("rxclk_en", 64'(rx8), 64'(e_rx));
        chk("txclk_en", 64'(tx8), 64'(e_tx));
        chk("inc_busy", 64'(busy8), 64'(m_busy));
        if (rst_n) begin
            r24 = r24 + longint'(rx24);
            t24 = t24 + longint'(tx24);
        end else begin
            chk("rst_rx24", 64'(rx24), 64'd0);
            chk("rst_tx24", 64'(tx24), 64'd0);
            chk("rst_busy24", 64'(busy24), 64'd0);
        end
    endtask

    task automatic do_reset();
        en = 1'b0; inc_load = 1'b0; rx_resync = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic load_inc(input logic [7:0] v);
        en = 1'b0; inc_load = 1'b1; inc_in = v;
        step();
        chk("load_busy_set", 64'(busy8), 64'd1);
        inc_load = 1'b0;
        step();
        chk("load_busy_clr", 64'(busy8), 64'd0);
        en = 1'b1;
    endtask

    initial begin
        int rxc, txc, last, nint, gap;
        int pat [3];
        pat[0] = 3; pat[1] = 3; pat[2] = 2;

        // reset asserted asynchronously before any edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rx8", 64'(rx8), 64'd0);
        chk("rst_tx8", 64'(tx8), 64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_rx24_async", 64'(rx24), 64'd0);
        chk("rst_tx24_async", 64'(tx24), 64'd0);
        do_reset();

        // randomized traffic on the 8-bit instance; 24-bit free-runs at defaults
        for (int i = 0; i < 20000; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            inc_load  = ($urandom_range(0, 49) == 0);
            inc_in    = 8'($urandom_range(0, 255));
            rx_resync = ($urandom_range(0, 39) == 0);
            step();
        end
        inc_load = 1'b0; rx_resync = 1'b0;
        chk("rate24_rx", 64'(r24), 64'((n24 * INC24) >> 24));
        chk("rate24_tx", 64'(t24), 64'(((n24 * INC24) >> 24) / 16));

        // integer divide: inc 64
        do_reset();
        load_inc(8'd64);
        rxc = 0; txc = 0;
        for (int i = 1; i <= 128; i++) begin
            step();
            chk("int_rx_slot", 64'(rx8), 64'((i % 4) == 0));
            chk("int_tx_slot", 64'(tx8), 64'((i % 64) == 0));
            rxc += int'(rx8); txc += int'(tx8);
        end
        chk("int_rx_count", 64'(rxc), 64'd32);
        chk("int_tx_count", 64'(txc), 64'd2);

        // fractional: inc 96 gives intervals 3,3,2
        do_reset();
        load_inc(8'd96);
        rxc = 0; last = 0; nint = 0;
        for (int i = 1; i <= 800; i++) begin
            step();
            if (rx8 === 1'b1) begin
                gap = i - last;
                if (nint < 6) chk("frac_interval", 64'(gap), 64'(pat[nint % 3]));
                nint++;
                last = i;
                rxc++;
            end
        end
        chk("frac_count", 64'(rxc), 64'd300);

        // glitch-free load 64 -> 32 mid-period, then an en pause
        do_reset();
        load_inc(8'd64);
        for (int i = 1; i <= 6; i++) step();
        inc_load = 1'b1; inc_in = 8'd32;
        step();
        inc_load = 1'b0;
        chk("glitch_busy_held", 64'(busy8), 64'd1);
        chk("glitch_no_tick", 64'(rx8), 64'd0);
        step();
        chk("glitch_tick", 64'(rx8), 64'd1);
        chk("glitch_busy_clr", 64'(busy8), 64'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("glitch_gap8", 64'(rx8), 64'(k == 8));
        end
        for (int k = 1; k <= 3; k++) step();
        en = 1'b0;
        rxc = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            rxc += int'(rx8) + int'(tx8);
        end
        chk("pause_no_ticks", 64'(rxc), 64'd0);
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("pause_resume", 64'(rx8), 64'(k == 5));
        end

        // resync on a carry edge with inc 64
        do_reset();
        load_inc(8'd64);
        for (int i = 1; i <= 7; i++) step();
        rx_resync = 1'b1;
        step();
        rx_resync = 1'b0;
        chk("resync_suppress", 64'(rx8), 64'd0);
        step();
        chk("resync_gap1", 64'(rx8), 64'd0);
        step();
        chk("resync_gap2", 64'(rx8), 64'd1);
        for (int i = 11; i <= 64; i++) begin
            step();
            chk("resync_tx_slot", 64'(tx8), 64'(i == 64));
        end

        // mid-operation async reset with a load coinciding with an apply
        do_reset();
        load_inc(8'd64);
        for (int i = 1; i <= 2; i++) step();
        inc_load = 1'b1; inc_in = 8'd100;
        step();
        inc_in = 8'd32;
        step();
        inc_load = 1'b0;
        chk("coincide_tick", 64'(rx8), 64'd1);
        chk("coincide_busy", 64'(busy8), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rx", 64'(rx8), 64'd0);
        chk("async_busy", 64'(busy8), 64'd0);
        step();
        rst_n = 1'b1;
        en = 1'b1;
        rxc = 0;
        for (int i = 1; i <= 256; i++) begin
            step();
            rxc += int'(rx8);
        end
        chk("default_inc_rate", 64'(rxc), 64'(DEF8));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
